// File: rtl/ads_serial_capture_if.sv
// Output stream bundle for ads_serial_capture.
// One channel word per beat, valid/ready handshake.
interface ads_serial_capture_if #(
  parameter int DATA_WIDTH = 24,
  parameter int CH_W       = 1
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ads_serial_capture.sv
// Serial capture engine for ADS167x-class ADCs.
// START/DRDY sequencing, SCLK shift-in, one-frame drain buffer.
module ads_serial_capture #(
  parameter int DATA_WIDTH     = 24,
  parameter int NUM_CH         = 1,
  parameter int SCLK_DIV       = 4,
  parameter int TIMEOUT_CYCLES = 1 << 20,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic measure,
  input  logic continuous,
  input  logic stop,
  input  logic err_clr,
  input  logic drdy_n,
  input  logic drr,
  output logic sclk,
  output logic start,
  output logic busy,
  output logic overrun,
  output logic timeout,
  ads_serial_capture_if.master out_if
);

  localparam int TOTAL = NUM_CH * DATA_WIDTH;
  localparam int HALF  = SCLK_DIV / 2;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int DW    = $clog2(SCLK_DIV);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_SHIFT,
    S_LOAD
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q, sync_d;
  logic              cont_q, cont_d;
  logic              stop_q, stop_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [TOTAL-1:0]  shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              start_q, start_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic [TOTAL-1:0]  buf_q, buf_d;
  logic              full_q, full_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;

  logic fall;
  logic keep;
  logic load;
  logic to_set;
  logic ov_set;
  logic fire;
  logic last_ch;

  // drdy_n synchronizer plus one extra stage for fall detection
  always_comb begin
    sync_d = {sync_q[1:0], drdy_n};
    fall   = sync_q[2] & ~sync_q[1];
  end

  // capture FSM: start/sclk sequencing, timeout, shift register
  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    start_d = start_q;
    to_set  = 1'b0;
    load    = 1'b0;
    keep    = cont_q & ~stop_q & ~stop;
    unique case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        if (measure) begin
          cont_d  = continuous;
          stop_d  = 1'b0;
          tcnt_d  = '0;
          state_d = S_ARM;
          start_d = 1'b1;
        end
      end
      S_ARM: begin
        tcnt_d  = tcnt_q + 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (fall) begin
          state_d = S_SHIFT;
          dcnt_d  = '0;
          bcnt_d  = '0;
        end else if (tcnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          to_set  = 1'b1;
          state_d = S_IDLE;
          start_d = 1'b0;
        end else if (cont_q && stop) begin
          state_d = S_IDLE;
          start_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (stop) stop_d = 1'b1;
        if (dcnt_q == DW'(SCLK_DIV - 1)) dcnt_d = '0;
        else dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DW'(HALF - 1)) begin
          shreg_d = {shreg_q[TOTAL-2:0], drr};
          bcnt_d  = bcnt_q + 1'b1;
        end
        if (dcnt_q == DW'(SCLK_DIV - 1) && bcnt_q == BW'(TOTAL)) begin
          state_d = S_LOAD;
          start_d = keep;
        end
      end
      S_LOAD: begin
        load   = 1'b1;
        bcnt_d = '0;
        dcnt_d = '0;
        if (keep) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
          start_d = 1'b1;
        end else begin
          state_d = S_IDLE;
          start_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
      end
    endcase
    sclk_d = (state_d == S_SHIFT) && (dcnt_d < DW'(HALF));
  end

  // drain buffer: shifts one word out per accepted beat
  always_comb begin
    buf_d   = buf_q;
    full_d  = full_q;
    rd_ch_d = rd_ch_q;
    ov_set  = 1'b0;
    last_ch = (rd_ch_q == CH_W'(NUM_CH - 1));
    fire    = full_q & out_if.out_ready;
    if (fire) begin
      buf_d = buf_q << DATA_WIDTH;
      if (last_ch) begin
        full_d  = 1'b0;
        rd_ch_d = '0;
      end else begin
        rd_ch_d = rd_ch_q + 1'b1;
      end
    end
    if (load) begin
      if (!full_q || (fire && last_ch)) begin
        buf_d   = shreg_q;
        full_d  = 1'b1;
        rd_ch_d = '0;
      end else begin
        ov_set = 1'b1;
      end
    end
  end

  // sticky error flags; a set event beats a clear
  always_comb begin
    timeout_d = to_set | (timeout_q & ~err_clr);
    overrun_d = ov_set | (overrun_q & ~err_clr);
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync_q    <= 3'b111;
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      buf_q     <= '0;
      full_q    <= 1'b0;
      rd_ch_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cont_q    <= cont_d;
      stop_q    <= stop_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
      full_q    <= full_d;
      rd_ch_q   <= rd_ch_d;
    end
  end

  // output mapping
  always_comb begin
    sclk             = sclk_q;
    start            = start_q;
    busy             = (state_q != S_IDLE);
    overrun          = overrun_q;
    timeout          = timeout_q;
    out_if.out_data  = buf_q[TOTAL-1 -: DATA_WIDTH];
    out_if.out_ch    = rd_ch_q;
    out_if.out_last  = full_q & last_ch;
    out_if.out_valid = full_q;
  end

endmodule

// File: tb/tb_ads_serial_capture.sv
// Scoreboard bench for ads_serial_capture.
// Four-channel daisy chain, short timeout, ADC behavioural model.
module tb_ads_serial_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic measure = 1'b0;
  logic continuous = 1'b0;
  logic stop = 1'b0;
  logic err_clr = 1'b0;
  logic drdy_n = 1'b1;
  logic drr = 1'b0;
  logic out_ready = 1'b1;
  logic sclk, start, busy, overrun, timeout;

  ads_serial_capture_if #(.DATA_WIDTH(24), .CH_W(2)) sif ();
  assign sif.out_ready = out_ready;

  ads_serial_capture #(
    .DATA_WIDTH(24),
    .NUM_CH(4),
    .SCLK_DIV(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .measure(measure),
    .continuous(continuous),
    .stop(stop),
    .err_clr(err_clr),
    .drdy_n(drdy_n),
    .drr(drr),
    .sclk(sclk),
    .start(start),
    .busy(busy),
    .overrun(overrun),
    .timeout(timeout),
    .out_if(sif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic [1:0]  ch;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: stall stability and in-order beat comparison
  logic        hold_v = 1'b0;
  logic [23:0] hold_d;
  logic [1:0]  hold_ch;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && sif.out_valid) begin
        chk("stall_data", sif.out_data, hold_d);
        chk("stall_ch", sif.out_ch, hold_ch);
      end
      if (sif.out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", sif.out_data, e.d);
          chk("beat_ch", sif.out_ch, e.ch);
          chk("beat_last", sif.out_last, e.last);
        end
      end
      hold_v  = sif.out_valid && !out_ready;
      hold_d  = sif.out_data;
      hold_ch = sif.out_ch;
    end
  end

  task automatic push_frame(input logic [95:0] f);
    for (int c = 0; c < 4; c++) begin
      exp_t e;
      e.d = f[95-24*c -: 24];
      e.ch = 2'(c);
      e.last = (c == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_measure(input logic cont);
    @(posedge clk);
    #1 measure = 1'b1;
    continuous = cont;
    @(posedge clk);
    #1 measure = 1'b0;
    chk("start_after_measure", start, 1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  // ADC model: DRDY fall, then one bit per sclk rise, MSB of ch0 first
  task automatic adc_frame(input logic [95:0] f, input int stop_at,
                           input int rst_at);
    logic prev;
    bit ok;
    cyc(20);
    drdy_n = 1'b0;
    for (int i = 0; i < 96; i++) begin
      ok = 0;
      prev = sclk;
      for (int n = 0; n < 50 && !ok; n++) begin
        cyc(1);
        if (sclk && !prev) ok = 1;
        prev = sclk;
      end
      if (!ok) begin
        chk("sclk_rise_timeout", 0, 1);
        drdy_n = 1'b1;
        return;
      end
      drdy_n = 1'b1;
      drr = f[95-i];
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_data", sif.out_data, 0);
        chk("rst_overrun", overrun, 0);
        return;
      end
      if (i == stop_at) pulse_stop();
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      cyc(1);
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  localparam logic [95:0] FA = {24'hA5C31F, 24'h000001,
                                24'h800000, 24'hFFFFFF};
  localparam logic [95:0] FB = {24'h000001, 24'h800000,
                                24'hFFFFFF, 24'h123456};
  localparam logic [95:0] FC = {24'h111111, 24'h222222,
                                24'h333333, 24'h444444};
  localparam logic [95:0] FD = {24'hDEADBE, 24'h0F0F0F,
                                24'hF0F0F0, 24'h5A5A5A};

  initial begin
    int n;
    cyc(3);
    chk("reset_start", start, 0);
    chk("reset_sclk", sclk, 0);
    chk("reset_valid", sif.out_valid, 0);
    chk("reset_data", sif.out_data, 0);
    chk("reset_ch", sif.out_ch, 0);
    chk("reset_last", sif.out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_timeout", timeout, 0);
    rst = 1'b0;
    cyc(2);

    // single frame, ready high
    do_measure(1'b0);
    push_frame(FA);
    adc_frame(FA, -1, -1);
    wait_idle("single_idle");
    chk("single_start_low", start, 0);
    wait_drain("single_drain");

    // single frame with consumer stalled 10 cycles
    out_ready = 1'b0;
    do_measure(1'b0);
    push_frame(FB);
    adc_frame(FB, -1, -1);
    n = 0;
    while (!sif.out_valid && n < 50) begin
      cyc(1);
      n++;
    end
    chk("stall_valid_seen", sif.out_valid, 1);
    cyc(10);
    out_ready = 1'b1;
    wait_drain("stall_drain");

    // continuous: three frames, stop in the middle of the third
    do_measure(1'b1);
    push_frame(FC);
    adc_frame(FC, -1, -1);
    push_frame(FD);
    adc_frame(FD, -1, -1);
    push_frame(FB);
    adc_frame(FB, 40, -1);
    chk("cont_busy_after_frame", busy, 1);
    wait_idle("cont_idle");
    chk("cont_start_low", start, 0);
    wait_drain("cont_drain");

    // overrun: two frames with no consumer
    out_ready = 1'b0;
    do_measure(1'b1);
    push_frame(FD);
    adc_frame(FD, -1, -1);
    cyc(10);
    chk("overrun_before", overrun, 0);
    adc_frame(FC, -1, -1);
    cyc(10);
    chk("overrun_set", overrun, 1);
    pulse_stop();
    cyc(3);
    chk("overrun_idle", busy, 0);
    out_ready = 1'b1;
    wait_drain("overrun_drain");
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("overrun_clear", overrun, 0);

    // timeout: DRDY never arrives
    do_measure(1'b0);
    n = 1;
    while (!timeout && n < 300) begin
      cyc(1);
      n++;
    end
    chk("timeout_set", timeout, 1);
    chk("timeout_latency_ok", (n >= 98 && n <= 102), 1);
    chk("timeout_start_low", start, 0);
    chk("timeout_idle", busy, 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("timeout_clear", timeout, 0);
    do_measure(1'b0);
    push_frame(FC);
    adc_frame(FC, -1, -1);
    wait_idle("after_timeout_idle");
    wait_drain("after_timeout_drain");

    // async reset at bit 10, then a clean frame
    do_measure(1'b0);
    adc_frame(FA, -1, 10);
    cyc(2);
    rst = 1'b0;
    drr = 1'b0;
    cyc(2);
    chk("post_rst_valid", sif.out_valid, 0);
    do_measure(1'b0);
    push_frame(FD);
    adc_frame(FD, -1, -1);
    wait_idle("post_rst_idle");
    wait_drain("post_rst_drain");

    cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
